// File: rtl/tank_ctrl_if.sv
// Per-player tank bus: keyboard slots and heading sin/cos in, pose and fire strobe out.
interface tank_ctrl_if;
  logic [31:0] keycode;
  logic [7:0]  sin;
  logic [7:0]  cos;
  logic [9:0]  TankX;
  logic [9:0]  TankY;
  logic [9:0]  TankS;
  logic [5:0]  Angle;
  logic        ShootBullet;

  modport master (
    output keycode, sin, cos,
    input  TankX, TankY, TankS, Angle, ShootBullet
  );

  modport slave (
    input  keycode, sin, cos,
    output TankX, TankY, TankS, Angle, ShootBullet
  );
endinterface

// File: rtl/tank_ctrl.sv
// Tank drive/rotate/fire controller: keys at frame edge N show on outputs right after edge N; no backpressure.
// Define TANK_WRAP_EN to wrap position at the travel limits instead of clamping.
module tank_ctrl #(
  parameter int         X_INIT        = 320,
  parameter int         Y_INIT        = 240,
  parameter int         X_MIN         = 0,
  parameter int         X_MAX         = 639,
  parameter int         Y_MIN         = 0,
  parameter int         Y_MAX         = 479,
  parameter int         SIZE          = 10,
  parameter logic [7:0] KEY_FWD       = 8'h1A,
  parameter logic [7:0] KEY_BACK      = 8'h16,
  parameter logic [7:0] KEY_LEFT      = 8'h04,
  parameter logic [7:0] KEY_RIGHT     = 8'h07,
  parameter logic [7:0] KEY_FIRE      = 8'h2C,
  parameter int         ROT_DIV       = 4,
  parameter int         FIRE_COOLDOWN = 30
) (
  input logic        frame_clk,
  input logic        Reset,
  tank_ctrl_if.slave bus
);

  localparam logic signed [16:0] X_LO = 17'(X_MIN * 64);
  localparam logic signed [16:0] X_HI = 17'(X_MAX * 64 + 63);
  localparam logic signed [16:0] Y_LO = 17'(Y_MIN * 64);
  localparam logic signed [16:0] Y_HI = 17'(Y_MAX * 64 + 63);
  localparam logic [3:0]         ROT_LAST = 4'(ROT_DIV - 1);
  localparam logic [7:0]         CD_LOAD  = 8'(FIRE_COOLDOWN);

  logic [15:0] x_acc_q, x_acc_d;
  logic [15:0] y_acc_q, y_acc_d;
  logic [5:0]  angle_q, angle_d;
  logic [3:0]  rot_cnt_q, rot_cnt_d;
  logic [7:0]  cooldown_q, cooldown_d;
  logic        fire_q, fire_d;
  logic        shoot_q, shoot_d;

  logic key_fwd, key_back, key_left, key_right, key_fire;
  logic signed [16:0] sin_ext, cos_ext, dx, dy;

  // Accumulators are 10.6 fixed point; the sum is evaluated in 17-bit signed.
  function automatic logic [15:0] axis_next(input logic [15:0]        acc,
                                            input logic signed [16:0] delta,
                                            input logic signed [16:0] lo,
                                            input logic signed [16:0] hi);
    logic signed [16:0] sum;
    logic [15:0]        r;
    sum = $signed({1'b0, acc}) + delta;
    r   = sum[15:0];
`ifdef TANK_WRAP_EN
    if (sum < lo)      r = hi[15:0];
    else if (sum > hi) r = lo[15:0];
`else
    if (sum < lo)      r = lo[15:0];
    else if (sum > hi) r = hi[15:0];
`endif
    return r;
  endfunction

  always_comb begin
    key_fwd   = 1'b0;
    key_back  = 1'b0;
    key_left  = 1'b0;
    key_right = 1'b0;
    key_fire  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      key_fwd   = key_fwd   | (bus.keycode[8*i +: 8] == KEY_FWD);
      key_back  = key_back  | (bus.keycode[8*i +: 8] == KEY_BACK);
      key_left  = key_left  | (bus.keycode[8*i +: 8] == KEY_LEFT);
      key_right = key_right | (bus.keycode[8*i +: 8] == KEY_RIGHT);
      key_fire  = key_fire  | (bus.keycode[8*i +: 8] == KEY_FIRE);
    end
  end

  always_comb begin
    sin_ext = 17'(signed'(bus.sin));
    cos_ext = 17'(signed'(bus.cos));
    dx      = '0;
    dy      = '0;
    // Screen Y grows downward, so a positive sine moves the tank up.
    if (key_fwd && !key_back) begin
      dx = cos_ext;
      dy = -sin_ext;
    end else if (key_back && !key_fwd) begin
      dx = -cos_ext;
      dy = sin_ext;
    end
    x_acc_d = axis_next(x_acc_q, dx, X_LO, X_HI);
    y_acc_d = axis_next(y_acc_q, dy, Y_LO, Y_HI);
  end

  always_comb begin
    angle_d   = angle_q;
    rot_cnt_d = '0;
    if (key_left != key_right) begin
      if (rot_cnt_q == ROT_LAST) begin
        angle_d = angle_q + (key_left ? 6'h3F : 6'h01);
      end else begin
        rot_cnt_d = rot_cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    fire_d     = key_fire;
    shoot_d    = key_fire && !fire_q && (cooldown_q == 8'd0);
    cooldown_d = cooldown_q;
    if (shoot_d)                 cooldown_d = CD_LOAD;
    else if (cooldown_q != 8'd0) cooldown_d = cooldown_q - 8'd1;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      x_acc_q    <= 16'(X_INIT * 64);
      y_acc_q    <= 16'(Y_INIT * 64);
      angle_q    <= '0;
      rot_cnt_q  <= '0;
      cooldown_q <= '0;
      fire_q     <= 1'b0;
      shoot_q    <= 1'b0;
    end else begin
      x_acc_q    <= x_acc_d;
      y_acc_q    <= y_acc_d;
      angle_q    <= angle_d;
      rot_cnt_q  <= rot_cnt_d;
      cooldown_q <= cooldown_d;
      fire_q     <= fire_d;
      shoot_q    <= shoot_d;
    end
  end

  assign bus.TankX       = x_acc_q[15:6];
  assign bus.TankY       = y_acc_q[15:6];
  assign bus.TankS       = 10'(SIZE);
  assign bus.Angle       = angle_q;
  assign bus.ShootBullet = shoot_q;

endmodule
